// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small FIFO.
// Frame: start 0, data LSB first, optional parity, stop bits of 1.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 full,
  output logic                 busy,
  output logic                 TX,
  output logic                 tx_done
);
  localparam int BW  = $clog2(BAUD_DIV);
  localparam int CW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [AW:0]    DEPTH     = AW1'(FIFO_DEPTH);
  localparam logic           ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 baud_end;
  logic                 stop_end;

  assign full     = (count == DEPTH);
  assign busy     = (state != IDLE) || (count != '0);
  assign push     = trmt && !full;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign stop_end = (state == STOP) && baud_end
                    && (bit_cnt == STOP_LAST);
  // Back-to-back frames: pop on the last stop clock.
  assign pop      = (count != '0)
                    && ((state == IDLE) || stop_end);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      TX       <= 1'b1;
    end else if (pop) begin
      state    <= START;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= head;
      par_bit  <= (^head) ^ ODD;
      TX       <= 1'b0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      TX       <= 1'b1;
    end else if (!baud_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      unique case (state)
        START: begin
          state <= DATA;
          TX    <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            if (PARITY != 0) begin
              state <= PAR;
              TX    <= par_bit;
            end else begin
              state <= STOP;
              TX    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            TX      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PAR: begin
          state <= STOP;
          TX    <= 1'b1;
        end
        STOP: begin
          if (bit_cnt == STOP_LAST) state <= IDLE;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A push clearing tx_done wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
    end else if (push) begin
      tx_done <= 1'b0;
    end else if (stop_end && (count == '0)) begin
      tx_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two configurations checked every cycle against
// a frame-level model (FIFO queue plus clocks-left-in-frame).
module tb_uart_tx_fifo;
  localparam int NI = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] trmt;
  logic [7:0] din0;
  logic [6:0] din1;
  logic [1:0] full;
  logic [1:0] busy;
  logic [1:0] tx;
  logic [1:0] done;

  int c_db[NI]    = '{8, 7};
  int c_baud[NI]  = '{16, 5};
  int c_par[NI]   = '{0, 2};
  int c_stop[NI]  = '{1, 2};
  int c_dep[NI]   = '{4, 2};

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DATA_BITS(8), .BAUD_DIV(16), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt[0]),
    .tx_data(din0), .full(full[0]), .busy(busy[0]),
    .TX(tx[0]), .tx_done(done[0])
  );

  uart_tx_fifo #(
    .DATA_BITS(7), .BAUD_DIV(5), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt[1]),
    .tx_data(din1), .full(full[1]), .busy(busy[1]),
    .TX(tx[1]), .tx_done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: queued bytes, clocks left in the current frame.
  logic [7:0] mf [NI][16];
  int         msz [NI]  = '{0, 0};
  int         rem [NI]  = '{0, 0};
  logic [7:0] cur [NI];
  logic       mdone [NI] = '{1'b0, 1'b0};
  int         pre;
  bit         fin, st, acc;

  function automatic int flen(int i);
    return (1 + c_db[i] + int'(c_par[i] != 0) + c_stop[i]) * c_baud[i];
  endfunction

  function automatic logic [7:0] din(int i);
    return (i == 0) ? din0 : {1'b0, din1};
  endfunction

  function automatic logic frame_bit(int i, logic [7:0] d, int pos);
    logic p;
    if (pos == 0) return 1'b0;
    if (pos <= c_db[i]) return d[pos-1];
    if (c_par[i] != 0 && pos == c_db[i] + 1) begin
      p = 1'b0;
      for (int k = 0; k < c_db[i]; k++) p ^= d[k];
      return (c_par[i] == 2) ? ~p : p;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_tx(int i);
    if (rem[i] == 0) return 1'b1;
    return frame_bit(i, cur[i], (flen(i) - rem[i]) / c_baud[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        msz[i] = 0;
        rem[i] = 0;
        mdone[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        pre = msz[i];
        fin = (rem[i] == 1);
        st  = (rem[i] <= 1) && (pre != 0);
        acc = trmt[i] && (pre < c_dep[i]);
        if (st) begin
          cur[i] = mf[i][0];
          for (int k = 0; k < 15; k++) mf[i][k] = mf[i][k+1];
          msz[i] = msz[i] - 1;
          rem[i] = flen(i);
        end else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
        end
        if (acc) begin
          mf[i][msz[i]] = din(i);
          msz[i] = msz[i] + 1;
          mdone[i] = 1'b0;
        end else if (fin && pre == 0) begin
          mdone[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("tx%0d", i), int'(tx[i]), int'(exp_tx(i)));
      chk($sformatf("busy%0d", i), int'(busy[i]),
          int'(rem[i] > 0 || msz[i] > 0));
      chk($sformatf("full%0d", i), int'(full[i]),
          int'(msz[i] == c_dep[i]));
      chk($sformatf("done%0d", i), int'(done[i]), int'(mdone[i]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(int i, logic [7:0] d);
    if (i == 0) din0 = d;
    else din1 = d[6:0];
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while ((rem[0] + rem[1] + msz[0] + msz[1]) != 0 && n < 3000) begin
      tick;
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(n < 3000), 1);
  endtask

  task automatic wait_end(int i, int sz, string nm);
    int n;
    n = 0;
    while (!(rem[i] == 1 && msz[i] == sz) && n < 3000) begin
      tick;
      n++;
    end
    chk({nm, "_end_timeout"}, int'(n < 3000), 1);
  endtask

  task automatic frame_lit(int i, logic [7:0] d, int nbits,
                           logic [15:0] bits, string nm);
    int b, len, k;
    b = c_baud[i];
    len = nbits * b;
    trmt[i] = 1'b1;
    set_din(i, d);
    tick;
    trmt[i] = 1'b0;
    chk({nm, "_pre"}, int'(tx[i]), 1);
    tick;
    chk({nm, "_start"}, int'(tx[i]), 0);
    for (k = 1; k <= len + 20; k++) begin
      tick;
      if (k % b == b / 2 && k / b < nbits)
        chk($sformatf("%s_bit%0d", nm, k / b), int'(tx[i]),
            int'(bits[k/b]));
      if (done[i]) break;
    end
    chk({nm, "_len"}, k, len);
    chk({nm, "_busy"}, int'(busy[i]), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b1;
    trmt  = '0;
    din0  = '0;
    din1  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", int'(tx), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (3) tick;

    frame_lit(0, 8'hA5, 10, 16'h034A, "a5");
    frame_lit(1, 8'h53, 11, 16'h07A6, "p53");

    // Six pushes: one goes straight to the shifter, four fill.
    for (int n = 1; n <= 6; n++) begin
      trmt[0] = 1'b1;
      din0 = 8'(n);
      tick;
      if (n == 4) chk("burst_notfull", int'(full[0]), 0);
      if (n == 5) chk("burst_full", int'(full[0]), 1);
    end
    trmt[0] = 1'b0;
    for (k = 0; k < 1000 && !done[0]; k++) tick;
    chk("burst_len", k, 796);

    trmt[0] = 1'b1;
    din0 = 8'h5A;
    tick;
    trmt[0] = 1'b0;
    chk("done_clr", int'(done[0]), 0);
    wait_end(0, 0, "win");
    trmt[0] = 1'b1;
    din0 = 8'h77;
    tick;
    trmt[0] = 1'b0;
    chk("done_push_win", int'(done[0]), 0);
    chk("gap_idle", int'(tx[0]), 1);
    tick;
    chk("restart", int'(tx[0]), 0);
    wait_idle("win");

    for (int n = 0; n < 3; n++) begin
      trmt[1] = 1'b1;
      din1 = 7'(8'h11 * (n + 1));
      tick;
    end
    trmt[1] = 1'b0;
    chk("fp_full", int'(full[1]), 1);
    wait_end(1, 2, "fp");
    trmt[1] = 1'b1;
    din1 = 7'h6E;
    tick;
    trmt[1] = 1'b0;
    chk("fp_drop_occ", int'(full[1]), 0);
    chk("fp_drop_busy", int'(busy[1]), 1);
    wait_idle("fp");

    for (int c = 0; c < 4000; c++) begin
      trmt[0] = ($urandom_range(0, 99) < 4);
      trmt[1] = ($urandom_range(0, 99) < 4);
      din0 = 8'($urandom);
      din1 = 7'($urandom);
      tick;
    end
    trmt = '0;
    wait_idle("rand");

    trmt[0] = 1'b1;
    din0 = 8'h3C;
    tick;
    din0 = 8'hC3;
    tick;
    trmt[0] = 1'b0;
    repeat (200) tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx), 3);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (300) tick;
    chk("post_rst_tx", int'(tx[0]), 1);
    chk("post_rst_busy", int'(busy[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
